// File: rtl/disp_pkg.sv
// Shared definitions for the multiplexed 7-segment display path: segment patterns,
// digit count, scan-sequencer states and the segment-to-BCD decoder.
package disp_pkg;

    localparam int NUM_DIGITS = 4;

    // Active-low patterns on seg[6:0], bit0 = a .. bit6 = g
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [3:0] BCD_BAD   = 4'hF;

    typedef enum logic [1:0] {
        EXP0 = 2'd0,
        EXP1 = 2'd1,
        EXP2 = 2'd2,
        EXP3 = 2'd3
    } seq_state_e;

    function automatic logic [3:0] seg_decode(input logic [6:0] pat);
        logic [3:0] digit;
        case (pat)
            SEG_0:   digit = 4'd0;
            SEG_1:   digit = 4'd1;
            SEG_2:   digit = 4'd2;
            SEG_3:   digit = 4'd3;
            SEG_4:   digit = 4'd4;
            SEG_5:   digit = 4'd5;
            SEG_6:   digit = 4'd6;
            SEG_7:   digit = 4'd7;
            SEG_8:   digit = 4'd8;
            SEG_9:   digit = 4'd9;
            default: digit = BCD_BAD;
        endcase
        return digit;
    endfunction

endpackage

// File: rtl/seg_mux_capture_if.sv
// Display-bus observation interface: scanned seg/sel inputs plus the
// de-multiplexed digit registers and status pulses produced from them.
interface seg_mux_capture_if;
    import disp_pkg::*;

    logic [7:0]              seg_in;
    logic [NUM_DIGITS-1:0]   sel_in;
    logic [8*NUM_DIGITS-1:0] seg_raw;
    logic [4*NUM_DIGITS-1:0] bcd;
    logic [NUM_DIGITS-1:0]   dp;
    logic [NUM_DIGITS-1:0]   digit_valid;
    logic                    frame_valid;
    logic                    sel_error;
    logic                    seq_error;
    logic                    stale;

    // Master side drives the display bus and observes the capture results
    modport master (
        output seg_in, sel_in,
        input  seg_raw, bcd, dp, digit_valid, frame_valid, sel_error, seq_error, stale
    );

    modport slave (
        input  seg_in, sel_in,
        output seg_raw, bcd, dp, digit_valid, frame_valid, sel_error, seq_error, stale
    );

endinterface

// File: rtl/bus_stabilizer.sv
// Two-flop synchroniser plus stability counter; emits one cap_evt per stable period.
// cap_evt fires STABLE_CYCLES+2 edges after an input change; no backpressure.
module bus_stabilizer #(
    parameter int WIDTH         = 12,
    parameter int STABLE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] bus_in,
    output logic [WIDTH-1:0] bus_stable,
    output logic             cap_evt
);

    localparam logic [7:0] CAP_CNT = 8'(STABLE_CYCLES - 1);

    logic [WIDTH-1:0] s1_q, s1_d;
    logic [WIDTH-1:0] s2_q, s2_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic [7:0]       stab_cnt_q, stab_cnt_d;
    logic             armed_q, armed_d;

    always_comb begin
        s1_d       = bus_in;
        s2_d       = s1_q;
        prev_d     = s2_q;
        stab_cnt_d = stab_cnt_q;
        armed_d    = armed_q;
        cap_evt    = armed_q && (s2_q == prev_q) && (stab_cnt_q == CAP_CNT);

        if (s2_q != prev_q) begin
            stab_cnt_d = 8'd0;
            armed_d    = 1'b1;
        end else begin
            if (stab_cnt_q != 8'hFF) begin
                stab_cnt_d = stab_cnt_q + 8'd1;
            end
            // Disarm so a held value is captured only once until the bus moves
            if (cap_evt) begin
                armed_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q       <= '0;
            s2_q       <= '0;
            prev_q     <= '0;
            stab_cnt_q <= 8'd0;
            armed_q    <= 1'b0;
        end else begin
            s1_q       <= s1_d;
            s2_q       <= s2_d;
            prev_q     <= prev_d;
            stab_cnt_q <= stab_cnt_d;
            armed_q    <= armed_d;
        end
    end

    assign bus_stable = s2_q;

endmodule

// File: rtl/seg_mux_capture.sv
// De-multiplexes a scanned 7-segment bus into per-digit registers, BCD and scan-order status.
// Outputs update STABLE_CYCLES+3 edges after a bus change; purely observational, no backpressure.
module seg_mux_capture
    import disp_pkg::*;
#(
    parameter int STABLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 25000000
) (
    input  logic              clk,
    input  logic              rst,
    seg_mux_capture_if.slave  bus
);

    localparam logic [31:0] TO_MAX = 32'(TIMEOUT_CYCLES);

    logic [11:0] stable_bus;
    logic        cap_evt;
    logic [7:0]  cap_seg;
    logic [3:0]  cap_sel;
    logic        one_hot;
    logic        multi_sel;
    logic [1:0]  k;
    logic [3:0]  dec;

    logic [31:0] seg_raw_q, seg_raw_d;
    logic [15:0] bcd_q, bcd_d;
    logic [3:0]  dp_q, dp_d;
    logic [3:0]  digit_valid_q, digit_valid_d;
    logic        frame_valid_q, frame_valid_d;
    logic        sel_error_q, sel_error_d;
    logic        seq_error_q, seq_error_d;
    logic [31:0] to_cnt_q, to_cnt_d;
    seq_state_e  state_q, state_d;

    bus_stabilizer #(
        .WIDTH         (12),
        .STABLE_CYCLES (STABLE_CYCLES)
    ) u_stab (
        .clk        (clk),
        .rst        (rst),
        .bus_in     ({bus.sel_in, bus.seg_in}),
        .bus_stable (stable_bus),
        .cap_evt    (cap_evt)
    );

    assign cap_seg   = stable_bus[7:0];
    assign cap_sel   = stable_bus[11:8];
    assign one_hot   = (cap_sel != 4'd0) && ((cap_sel & (cap_sel - 4'd1)) == 4'd0);
    assign multi_sel = (cap_sel != 4'd0) && !one_hot;
    assign dec       = seg_decode(cap_seg[6:0]);

    always_comb begin
        k = 2'd0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (cap_sel[i]) begin
                k = 2'(i);
            end
        end
    end

    always_comb begin
        seg_raw_d     = seg_raw_q;
        bcd_d         = bcd_q;
        dp_d          = dp_q;
        digit_valid_d = digit_valid_q;
        frame_valid_d = 1'b0;
        sel_error_d   = 1'b0;
        seq_error_d   = 1'b0;
        state_d       = state_q;
        to_cnt_d      = (to_cnt_q == TO_MAX) ? to_cnt_q : to_cnt_q + 32'd1;

        if (cap_evt && multi_sel) begin
            sel_error_d = 1'b1;
        end

        // Blanking captures (sel == 0) fall through both branches untouched
        if (cap_evt && one_hot) begin
            seg_raw_d[{k, 3'b000} +: 8] = cap_seg;
            bcd_d[{k, 2'b00} +: 4]      = dec;
            dp_d[k]                     = ~cap_seg[7];
            digit_valid_d[k]            = (dec != BCD_BAD);
            to_cnt_d                    = 32'd0;

            if (k == state_q) begin
                frame_valid_d = (state_q == EXP3);
                state_d       = seq_state_e'(k + 2'd1);
            end else begin
                seq_error_d = 1'b1;
                state_d     = (k == 2'd0) ? EXP1 : EXP0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_raw_q     <= 32'hFFFF_FFFF;
            bcd_q         <= 16'hFFFF;
            dp_q          <= 4'd0;
            digit_valid_q <= 4'd0;
            frame_valid_q <= 1'b0;
            sel_error_q   <= 1'b0;
            seq_error_q   <= 1'b0;
            to_cnt_q      <= 32'd0;
            state_q       <= EXP0;
        end else begin
            seg_raw_q     <= seg_raw_d;
            bcd_q         <= bcd_d;
            dp_q          <= dp_d;
            digit_valid_q <= digit_valid_d;
            frame_valid_q <= frame_valid_d;
            sel_error_q   <= sel_error_d;
            seq_error_q   <= seq_error_d;
            to_cnt_q      <= to_cnt_d;
            state_q       <= state_d;
        end
    end

    assign bus.seg_raw     = seg_raw_q;
    assign bus.bcd         = bcd_q;
    assign bus.dp          = dp_q;
    assign bus.digit_valid = digit_valid_q;
    assign bus.frame_valid = frame_valid_q;
    assign bus.sel_error   = sel_error_q;
    assign bus.seq_error   = seq_error_q;
    assign bus.stale       = (to_cnt_q == TO_MAX);

endmodule

// File: tb/tb_seg_mux_capture.sv
// Bench for seg_mux_capture: scan stimulus with a reference model feeding an expectation queue.
module tb_seg_mux_capture;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    seg_mux_capture_if dut_if ();

    seg_mux_capture #(
        .STABLE_CYCLES  (4),
        .TIMEOUT_CYCLES (100)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (dut_if)
    );

    typedef struct {
        logic [31:0] seg_raw;
        logic [15:0] bcd;
        logic [3:0]  dp;
        logic [3:0]  dv;
        int          fv;
        int          se;
        int          qe;
    } exp_t;

    exp_t exp_q[$];
    int n_vec = 0;
    int n_err = 0;
    int fv_cnt = 0, se_cnt = 0, qe_cnt = 0;
    int d_fv, d_se, d_qe;

    logic [31:0] m_raw;
    logic [15:0] m_bcd;
    logic [3:0]  m_dp, m_dv;
    int          m_state;

    always @(negedge clk) begin
        if (dut_if.frame_valid === 1'b1) fv_cnt++;
        if (dut_if.sel_error === 1'b1) se_cnt++;
        if (dut_if.seq_error === 1'b1) qe_cnt++;
    end

    function automatic logic [3:0] ref_decode(input logic [6:0] p);
        case (p)
            7'h40: return 4'd0;
            7'h79: return 4'd1;
            7'h24: return 4'd2;
            7'h30: return 4'd3;
            7'h19: return 4'd4;
            7'h12: return 4'd5;
            7'h02: return 4'd6;
            7'h78: return 4'd7;
            7'h00: return 4'd8;
            7'h10: return 4'd9;
            default: return 4'hF;
        endcase
    endfunction

    task automatic model_reset();
        m_raw   = 32'hFFFF_FFFF;
        m_bcd   = 16'hFFFF;
        m_dp    = 4'h0;
        m_dv    = 4'h0;
        m_state = 0;
    endtask

    task automatic model_push(input logic [7:0] seg, input logic [3:0] sel);
        exp_t e;
        int kk;
        e.fv = 0; e.se = 0; e.qe = 0;
        if (sel != 4'd0) begin
            if ($countones(sel) > 1) begin
                e.se = 1;
            end else begin
                kk = 0;
                for (int i = 0; i < 4; i++) if (sel[i]) kk = i;
                m_raw[kk*8 +: 8] = seg;
                m_bcd[kk*4 +: 4] = ref_decode(seg[6:0]);
                m_dp[kk]         = ~seg[7];
                m_dv[kk]         = (ref_decode(seg[6:0]) != 4'hF);
                if (kk == m_state) begin
                    if (kk == 3) e.fv = 1;
                    m_state = (kk + 1) % 4;
                end else begin
                    e.qe    = 1;
                    m_state = (kk == 0) ? 1 : 0;
                end
            end
        end
        e.seg_raw = m_raw; e.bcd = m_bcd; e.dp = m_dp; e.dv = m_dv;
        exp_q.push_back(e);
    endtask

    task automatic drive(input logic [7:0] seg, input logic [3:0] sel, input int hold);
        int f0, s0, q0;
        @(posedge clk); #1;
        dut_if.seg_in = seg;
        dut_if.sel_in = sel;
        model_push(seg, sel);
        f0 = fv_cnt; s0 = se_cnt; q0 = qe_cnt;
        repeat (hold) @(posedge clk);
        #2;
        d_fv = fv_cnt - f0; d_se = se_cnt - s0; d_qe = qe_cnt - q0;
    endtask

    task automatic test_reset();
        dut_if.seg_in = 8'hFF;
        dut_if.sel_in = 4'h0;
        rst = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        #2;
        n_vec++; if (dut_if.seg_raw !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL reset seg_raw: got %h want ffffffff", dut_if.seg_raw); end
        n_vec++; if (dut_if.bcd !== 16'hFFFF) begin n_err++; $display("FAIL reset bcd: got %h want ffff", dut_if.bcd); end
        n_vec++; if ({dut_if.dp, dut_if.digit_valid} !== 8'h00) begin n_err++; $display("FAIL reset dp/dv: got %h/%h want 0/0", dut_if.dp, dut_if.digit_valid); end
        n_vec++; if ({dut_if.frame_valid, dut_if.sel_error, dut_if.seq_error, dut_if.stale} !== 4'b0000) begin
            n_err++; $display("FAIL reset flags: got %b want 0000", {dut_if.frame_valid, dut_if.sel_error, dut_if.seq_error, dut_if.stale}); end
        @(posedge clk); #2;
        rst = 1'b0;
        repeat (10) @(posedge clk);
    endtask

    task automatic test_normal_scan();
        logic [7:0] segs [4];
        exp_t e;
        segs = '{8'hF9, 8'hA4, 8'hB0, 8'h99};
        for (int i = 0; i < 4; i++) begin
            drive(segs[i], 4'(1 << i), 20);
            e = exp_q.pop_front();
            n_vec++; if (dut_if.seg_raw !== e.seg_raw) begin n_err++; $display("FAIL scan%0d seg_raw: got %h want %h", i, dut_if.seg_raw, e.seg_raw); end
            n_vec++; if (dut_if.bcd !== e.bcd) begin n_err++; $display("FAIL scan%0d bcd: got %h want %h", i, dut_if.bcd, e.bcd); end
            n_vec++; if (d_fv !== e.fv) begin n_err++; $display("FAIL scan%0d frame pulses: got %0d want %0d", i, d_fv, e.fv); end
            n_vec++; if (d_se + d_qe !== 0) begin n_err++; $display("FAIL scan%0d errors: got %0d want 0", i, d_se + d_qe); end
        end
        n_vec++; if (dut_if.bcd !== 16'h4321) begin n_err++; $display("FAIL scan final bcd: got %h want 4321", dut_if.bcd); end
        n_vec++; if (dut_if.digit_valid !== 4'hF) begin n_err++; $display("FAIL scan digit_valid: got %h want f", dut_if.digit_valid); end
    endtask

    task automatic test_glitch();
        exp_t e;
        int q0, f0;
        drive(8'hC0, 4'b0001, 20);
        e = exp_q.pop_front();
        n_vec++; if (d_qe !== e.qe) begin n_err++; $display("FAIL glitch first seq_err: got %0d want %0d", d_qe, e.qe); end
        // 2-cycle excursion to 0x80 must never be captured
        @(posedge clk); #1;
        dut_if.seg_in = 8'h80;
        q0 = qe_cnt; f0 = fv_cnt;
        repeat (2) @(posedge clk); #1;
        dut_if.seg_in = 8'hC0;
        model_push(8'hC0, 4'b0001);
        repeat (20) @(posedge clk); #2;
        e = exp_q.pop_front();
        n_vec++; if (qe_cnt - q0 !== e.qe) begin n_err++; $display("FAIL glitch seq_err count: got %0d want %0d", qe_cnt - q0, e.qe); end
        n_vec++; if (fv_cnt - f0 !== e.fv) begin n_err++; $display("FAIL glitch frame count: got %0d want %0d", fv_cnt - f0, e.fv); end
        n_vec++; if (dut_if.bcd !== e.bcd) begin n_err++; $display("FAIL glitch bcd: got %h want %h", dut_if.bcd, e.bcd); end
        n_vec++; if (dut_if.seg_raw !== e.seg_raw) begin n_err++; $display("FAIL glitch seg_raw: got %h want %h", dut_if.seg_raw, e.seg_raw); end
    endtask

    task automatic test_bad_sel();
        exp_t e;
        drive(8'hC0, 4'b0110, 10);
        e = exp_q.pop_front();
        n_vec++; if (d_se !== e.se) begin n_err++; $display("FAIL badsel sel_err count: got %0d want %0d", d_se, e.se); end
        n_vec++; if (d_qe !== e.qe) begin n_err++; $display("FAIL badsel seq_err count: got %0d want %0d", d_qe, e.qe); end
        n_vec++; if (dut_if.seg_raw !== e.seg_raw) begin n_err++; $display("FAIL badsel seg_raw: got %h want %h", dut_if.seg_raw, e.seg_raw); end
        n_vec++; if (dut_if.bcd !== e.bcd) begin n_err++; $display("FAIL badsel bcd: got %h want %h", dut_if.bcd, e.bcd); end
    endtask

    task automatic test_out_of_order();
        logic [7:0] segs [6];
        logic [3:0] sels [6];
        exp_t e;
        segs = '{8'hC0, 8'hA4, 8'hC0, 8'hF9, 8'hA4, 8'hB0};
        sels = '{4'b0001, 4'b0100, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
        for (int i = 0; i < 6; i++) begin
            drive(segs[i], sels[i], 12);
            e = exp_q.pop_front();
            n_vec++; if (d_qe !== e.qe) begin n_err++; $display("FAIL order%0d seq_err: got %0d want %0d", i, d_qe, e.qe); end
            n_vec++; if (d_fv !== e.fv) begin n_err++; $display("FAIL order%0d frame: got %0d want %0d", i, d_fv, e.fv); end
            n_vec++; if (d_se !== e.se) begin n_err++; $display("FAIL order%0d sel_err: got %0d want %0d", i, d_se, e.se); end
        end
        n_vec++; if (dut_if.bcd !== 16'h3210) begin n_err++; $display("FAIL order final bcd: got %h want 3210", dut_if.bcd); end
    endtask

    task automatic test_unrecognised_dp();
        exp_t e;
        drive(8'h7F, 4'b0010, 12);
        e = exp_q.pop_front();
        n_vec++; if (dut_if.bcd[7:4] !== 4'hF) begin n_err++; $display("FAIL unrec bcd1: got %h want f", dut_if.bcd[7:4]); end
        n_vec++; if (dut_if.digit_valid !== e.dv) begin n_err++; $display("FAIL unrec digit_valid: got %h want %h", dut_if.digit_valid, e.dv); end
        n_vec++; if (dut_if.dp !== e.dp) begin n_err++; $display("FAIL unrec dp: got %h want %h", dut_if.dp, e.dp); end
        drive(8'h24, 4'b0100, 12);
        e = exp_q.pop_front();
        n_vec++; if (dut_if.bcd !== e.bcd) begin n_err++; $display("FAIL dp2 bcd: got %h want %h", dut_if.bcd, e.bcd); end
        n_vec++; if (dut_if.dp[2] !== 1'b1) begin n_err++; $display("FAIL dp2 dp[2]: got %b want 1", dut_if.dp[2]); end
        n_vec++; if (dut_if.digit_valid !== e.dv) begin n_err++; $display("FAIL dp2 digit_valid: got %h want %h", dut_if.digit_valid, e.dv); end
    endtask

    task automatic test_timeout();
        exp_t e;
        @(posedge clk); #1;
        dut_if.seg_in = 8'h99; dut_if.sel_in = 4'b1000;
        model_push(8'h99, 4'b1000);
        // capture lands on edge 7, stale 100 edges later
        repeat (106) @(posedge clk); #2;
        n_vec++; if (dut_if.stale !== 1'b0) begin n_err++; $display("FAIL timeout early stale: got %b want 0", dut_if.stale); end
        @(posedge clk); #2;
        n_vec++; if (dut_if.stale !== 1'b1) begin n_err++; $display("FAIL timeout stale: got %b want 1", dut_if.stale); end
        e = exp_q.pop_front();
        n_vec++; if (dut_if.bcd !== e.bcd) begin n_err++; $display("FAIL timeout bcd: got %h want %h", dut_if.bcd, e.bcd); end
        @(posedge clk); #1;
        dut_if.seg_in = 8'hF9; dut_if.sel_in = 4'b0001;
        model_push(8'hF9, 4'b0001);
        repeat (6) @(posedge clk); #2;
        n_vec++; if (dut_if.stale !== 1'b1) begin n_err++; $display("FAIL timeout held stale: got %b want 1", dut_if.stale); end
        @(posedge clk); #2;
        n_vec++; if (dut_if.stale !== 1'b0) begin n_err++; $display("FAIL timeout clear: got %b want 0", dut_if.stale); end
        e = exp_q.pop_front();
        n_vec++; if (dut_if.seg_raw !== e.seg_raw) begin n_err++; $display("FAIL timeout seg_raw: got %h want %h", dut_if.seg_raw, e.seg_raw); end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] segs [4];
        exp_t e;
        drive(8'hA4, 4'b0010, 12);
        e = exp_q.pop_front();
        n_vec++; if (dut_if.digit_valid !== e.dv) begin n_err++; $display("FAIL midrst pre dv: got %h want %h", dut_if.digit_valid, e.dv); end
        @(posedge clk); #2;
        rst = 1'b1;
        dut_if.seg_in = 8'hFF; dut_if.sel_in = 4'h0;
        model_reset();
        #1;
        n_vec++; if (dut_if.seg_raw !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL midrst seg_raw: got %h want ffffffff", dut_if.seg_raw); end
        n_vec++; if (dut_if.bcd !== 16'hFFFF) begin n_err++; $display("FAIL midrst bcd: got %h want ffff", dut_if.bcd); end
        n_vec++; if ({dut_if.dp, dut_if.digit_valid} !== 8'h00) begin n_err++; $display("FAIL midrst dp/dv: got %h/%h want 0/0", dut_if.dp, dut_if.digit_valid); end
        n_vec++; if (dut_if.stale !== 1'b0) begin n_err++; $display("FAIL midrst stale: got %b want 0", dut_if.stale); end
        @(posedge clk); #2;
        rst = 1'b0;
        repeat (10) @(posedge clk);
        segs = '{8'hF9, 8'hA4, 8'hB0, 8'h99};
        for (int i = 0; i < 4; i++) begin
            drive(segs[i], 4'(1 << i), 12);
            e = exp_q.pop_front();
            n_vec++; if (d_fv !== e.fv || d_qe !== e.qe) begin
                n_err++; $display("FAIL midrst scan%0d frame/seq: got %0d/%0d want %0d/%0d", i, d_fv, d_qe, e.fv, e.qe); end
        end
        n_vec++; if (dut_if.bcd !== 16'h4321) begin n_err++; $display("FAIL midrst final bcd: got %h want 4321", dut_if.bcd); end
    endtask

    initial begin
        dut_if.seg_in = 8'hFF;
        dut_if.sel_in = 4'h0;
        test_reset();
        test_normal_scan();
        test_glitch();
        test_bad_sel();
        test_out_of_order();
        test_unrecognised_dp();
        test_timeout();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/seg_mux_capture.md
Name: seg_mux_capture

Overview:
- Receive-side counterpart of the multiplexed 7-segment display driver.
- Watches the time-multiplexed segment bus and one-hot digit-select bus and de-multiplexes them back into four per-digit segment bytes.
- Decodes each digit to BCD, checks the scan order, and flags frame completion, protocol errors and a stalled scan.
- Used for on-board self-test and for loop-back verification of the display path.

Parameters:
- STABLE_CYCLES, 4: consecutive clk cycles the synchronised seg/sel pair must stay unchanged before it is captured (legal range 2..255).
- TIMEOUT_CYCLES, 25000000: clk cycles without a capture before stale asserts (32-bit counter).

Ports:
- clk  in  1  system clock, 50 MHz
- rst  in  1  asynchronous reset, active-high
- seg_in  in  8  segment bus; active-low; bit0=a .. bit6=g, bit7=dp
- sel_in  in  4  digit select; bit n selects digit n; one-hot when valid
- seg_raw  out  32  captured segment bytes; digit n in bits [8n+7:8n]
- bcd  out  16  decoded digits; digit n in bits [4n+3:4n]; 4'hF means unrecognised
- dp  out  4  decimal point per digit; 1 = lit (inverted seg bit7)
- digit_valid  out  4  bit n set once digit n has been captured with a recognised pattern
- frame_valid  out  1  one-cycle pulse when digits 0,1,2,3 have been captured in order
- sel_error  out  1  one-cycle pulse on a capture with more than one sel bit set
- seq_error  out  1  one-cycle pulse on an out-of-order capture
- stale  out  1  level; high while the timeout counter is saturated

Behaviour:
- Reset (async, rst=1):
  - seg_raw=32'hFFFF_FFFF, bcd=16'hFFFF, dp=0, digit_valid=0.
  - frame_valid, sel_error, seq_error and stale all 0.
  - FSM in EXP0; all counters 0; synchroniser flops 0.
  - Reset mid-frame discards partial frame state.
- Synchroniser: seg_in and sel_in are each registered through two flops (s1, s2).
- Stabiliser:
  - prev holds s2 from the previous cycle.
  - If s2 != prev, stab_cnt <= 0 and armed <= 1.
  - Otherwise stab_cnt increments, saturating at 255.
  - cap_evt = armed && (s2 == prev) && (stab_cnt == STABLE_CYCLES-1); armed clears on cap_evt.
  - Result: exactly one cap_evt per stable period. A held value never re-captures until the bus changes.
- Latency: outputs update on the edge after cap_evt, i.e. STABLE_CYCLES+3 edges after an input change (7 edges for the default).
- Capture rules on cap_evt:
  - sel = 0000 (blanking): ignored. No write, no error, no FSM change, timeout counter not reset.
  - sel with 2 or more bits set: sel_error pulse. No write, no FSM change.
  - sel one-hot, index k:
    - seg_raw[k] <= seg.
    - dp[k] <= ~seg[7].
    - bcd[k] <= decode(seg[6:0]).
    - digit_valid[k] <= (decode != 4'hF).
    - Timeout counter cleared; stale cleared.
- Decode table (seg[6:0] -> digit), all other patterns -> 4'hF:
  - 40->0, 79->1, 24->2, 30->3, 19->4
  - 12->5, 02->6, 78->7, 00->8, 10->9
- Sequencer FSM, states EXP0, EXP1, EXP2, EXP3; acts on one-hot captures only:
  - In EXPn with k == n: advance to EXP(n+1).
  - In EXP3 with k == 3: frame_valid pulse on the same edge as the register update, then go to EXP0.
  - k != expected: seq_error pulse. Next state is EXP1 if k == 0, otherwise EXP0 (resync on digit 0).
  - The register write happens regardless of sequence outcome.
- Timeout:
  - to_cnt increments every cycle without a one-hot capture and saturates at TIMEOUT_CYCLES.
  - stale = (to_cnt == TIMEOUT_CYCLES).
  - When a capture and saturation coincide, the capture wins: stale=0.
- Simultaneous events: sel_error and seq_error are never both asserted for the same cap_evt.

Decomposition:
- Shared package disp_pkg holds:
  - segment pattern constants SEG_0..SEG_9 and SEG_BLANK (7'h7F);
  - NUM_DIGITS = 4;
  - FSM state enum;
  - a decode function, also used by the driver's bench.
- One natural sub-module, bus_stabilizer: the 2-flop synchroniser plus stability counter producing the stable seg/sel pair and cap_evt.
- Capture registers, decode and FSM stay in the top level.

Test Plan:
- Normal scan: drive (F9,0001), (A4,0010), (B0,0100), (99,1000), each held 20 cycles -> bcd=16'h4321, digit_valid=4'hF, one frame_valid pulse, no errors.
- Glitch filter: hold (C0,0001), then change seg to 80 for 2 cycles and back to C0 -> no capture of 80; the return to C0 after 4 stable cycles captures again; bcd[3:0]=0.
- Bad select: sel=0110, seg=C0, held 10 cycles -> exactly one sel_error pulse; seg_raw, bcd and FSM unchanged.
- Out of order: capture digit 0, then digit 2 -> seq_error pulse, FSM back to EXP0; a following 0,1,2,3 scan yields frame_valid.
- Unrecognised pattern and dp: seg=0x7F on digit 1 -> bcd[7:4]=F, digit_valid[1]=0. Then seg=0x24 on digit 2 -> bcd[11:8]=2, dp[2]=1.
- Timeout and reset: TIMEOUT_CYCLES=100 with inputs frozen -> stale=1 at cycle 100 after the last capture, cleared by the next capture. Assert rst mid-frame -> all outputs return to reset values immediately (asynchronous).
